// File: rtl/wb_noc_bridge.sv
// -----------------------------------------------------------------------------
// wb_noc_bridge
//
// Wishbone B4 classic slave that buffers 32-bit host writes in a small FIFO and
// replays them, one entry per slot, onto the flat broadcast bus feeding the
// bus_repeater stage. Between replayed entries the bus carries IDLE_ADR, which
// lies outside every repeater window, so repeaters ignore idle cycles. Reads
// never touch the FIFO; they return a status word {fifo_full, count}.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i               1 = write (buffered), 0 = read (status)
//   wb_adr_i, wb_dat_i    write address / data, stored together per entry
//   wb_ack_o              registered single-cycle acknowledge
//   wb_dat_o              status word on read acks, zero otherwise
//   bus_adr, bus_dat      broadcast address / data (IDLE_ADR / 0 when idle)
//   bus_vld               high on cycles carrying a replayed entry
//   fifo_full             registered full flag
// -----------------------------------------------------------------------------
module wb_noc_bridge #(
  parameter int unsigned        WB_WID    = 32,
  parameter int unsigned        DEPTH     = 8,
  parameter int unsigned        DRAIN_GAP = 0,
  parameter logic [WB_WID-1:0]  IDLE_ADR  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [WB_WID-1:0] wb_adr_i,
  input  logic [WB_WID-1:0] wb_dat_i,
  output logic              wb_ack_o,
  output logic [WB_WID-1:0] wb_dat_o,
  output logic [WB_WID-1:0] bus_dat,
  output logic [WB_WID-1:0] bus_adr,
  output logic              bus_vld,
  output logic              fifo_full
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [7:0]       GAP_C   = 8'(DRAIN_GAP);
  localparam logic             GAP_EN  = (DRAIN_GAP != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [7:0]         gap_q, gap_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               fifo_full_q, fifo_full_d;
  logic               wb_ack_q, wb_ack_d;
  logic [WB_WID-1:0]  wb_dat_q, wb_dat_d;
  logic [WB_WID-1:0]  bus_adr_q, bus_adr_d;
  logic [WB_WID-1:0]  bus_dat_q, bus_dat_d;
  logic               bus_vld_q, bus_vld_d;

  // Entry storage: no reset, contents are only meaningful between the pointers.
  logic [WB_WID-1:0]  mem_adr_q [DEPTH];
  logic [WB_WID-1:0]  mem_dat_q [DEPTH];

  logic               req;
  logic               wr_req;
  logic               rd_req;
  logic               push;
  logic               pop;
  logic [7:0]         cnt8;
  logic [WB_WID-1:0]  status;
  logic [WB_WID-1:0]  head_adr;
  logic [WB_WID-1:0]  head_dat;

  // A request is masked while its ack is on the bus, which also guarantees
  // that two acks can never be back to back.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign wr_req = req & wb_we_i;
  assign rd_req = req & ~wb_we_i;

  // Space check uses the registered count only: an entry leaving this cycle
  // does not make room for a write arriving in the same cycle.
  assign push   = wr_req & (count_q != DEPTH_C);

  assign cnt8     = 8'(count_q);
  assign status   = WB_WID'({fifo_full_q, cnt8});
  assign head_adr = mem_adr_q[rd_ptr_q];
  assign head_dat = mem_dat_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Drain FSM, FIFO bookkeeping and Wishbone response
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    bus_vld_d = 1'b0;
    bus_adr_d = IDLE_ADR;
    bus_dat_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          bus_vld_d = 1'b1;
          bus_adr_d = head_adr;
          bus_dat_d = head_dat;
          if (GAP_EN) begin
            state_d = ST_GAP;
            gap_d   = GAP_C;
          end
        end
      end
      ST_GAP: begin
        // Counter is loaded with DRAIN_GAP on the pop, so exactly DRAIN_GAP
        // cycles are spent here before IDLE may pop again.
        if (gap_q <= 8'd1) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Power-of-two depth: pointer wrap is the natural overflow.
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_full_d = (count_d == DEPTH_C);

    wb_ack_d = rd_req | push;
    wb_dat_d = rd_req ? status : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_full_q <= 1'b0;
      wb_ack_q    <= 1'b0;
      wb_dat_q    <= '0;
      bus_adr_q   <= IDLE_ADR;
      bus_dat_q   <= '0;
      bus_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_full_q <= fifo_full_d;
      wb_ack_q    <= wb_ack_d;
      wb_dat_q    <= wb_dat_d;
      bus_adr_q   <= bus_adr_d;
      bus_dat_q   <= bus_dat_d;
      bus_vld_q   <= bus_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr_q[wr_ptr_q] <= wb_adr_i;
      mem_dat_q[wr_ptr_q] <= wb_dat_i;
    end
  end

  assign wb_ack_o  = wb_ack_q;
  assign wb_dat_o  = wb_dat_q;
  assign bus_adr   = bus_adr_q;
  assign bus_dat   = bus_dat_q;
  assign bus_vld   = bus_vld_q;
  assign fifo_full = fifo_full_q;

endmodule

// File: tb/tb_wb_noc_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_noc_bridge
//
// Four bridges with DRAIN_GAP = 0, 2, 3 and 255 run side by side on one clock,
// each with its own reset, driver, reference model and monitor.
//
// Reference model: every accepted write becomes an entry whose replay edge is
// max(push_edge + 1, previous_replay_edge + DRAIN_GAP + 1). The FIFO occupancy
// seen by a request is the number of accepted entries whose replay edge has
// not yet passed. Acks, status words, bus contents and the full flag are all
// derived from that list; the monitor pops expectations as the DUT presents
// its outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_noc_bridge;

  localparam int          NI            = 4;
  localparam int          DEPTH         = 8;
  localparam logic [31:0] IDLE          = 32'hFFFF_FFFF;
  localparam int          ACK_BUDGET    = 1000;
  localparam int          DRAIN_BUDGET  = 4000;
  localparam int          GLOBAL_BUDGET = 60000;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          edge_n;
  } bus_exp_t;

  typedef struct {
    int          edge_n;
    bit          is_rd;
    logic [31:0] dat;
  } wb_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic chk(input int inst, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%0t] g%0d %s actual=%h expected=%h", $time, inst, name, act, exp);
    end
  endtask

  task automatic fail_bound(input int inst, input string what);
    checks++;
    errors++;
    $display("FAIL [%0t] g%0d %s bound expired", $time, inst, what);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int G = (gi == 0) ? 0 : (gi == 1) ? 2 : (gi == 2) ? 3 : 255;

    logic        rst_n  = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we  = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_wdat = '0;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic [31:0] bus_dat;
    logic [31:0] bus_adr;
    logic        bus_vld;
    logic        fifo_full;

    wb_noc_bridge #(
      .WB_WID    (32),
      .DEPTH     (DEPTH),
      .DRAIN_GAP (G),
      .IDLE_ADR  (IDLE)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_cyc_i  (wb_cyc),
      .wb_stb_i  (wb_stb),
      .wb_we_i   (wb_we),
      .wb_adr_i  (wb_adr),
      .wb_dat_i  (wb_wdat),
      .wb_ack_o  (wb_ack),
      .wb_dat_o  (wb_rdat),
      .bus_dat   (bus_dat),
      .bus_adr   (bus_adr),
      .bus_vld   (bus_vld),
      .fifo_full (fifo_full)
    );

    // ------------------------------ model ---------------------------------
    bus_exp_t bq[$];
    wb_exp_t  wq[$];
    int       pend[$];
    int       ecnt     = 0;
    int       last_pop = -100000;
    bit       ack_prev = 1'b0;
    bit       exp_full = 1'b0;

    always @(negedge rst_n) begin
      bq.delete();
      wq.delete();
      pend.delete();
      last_pop = -100000;
      ack_prev = 1'b0;
      exp_full = 1'b0;
    end

    always @(posedge clk) begin : p_model
      int       cnt;
      int       p;
      bit       req;
      bus_exp_t be;
      wb_exp_t  we;
      ecnt++;
      if (rst_n) begin
        while (pend.size() > 0 && pend[0] <= ecnt - 1) void'(pend.pop_front());
        cnt = pend.size();
        req = wb_cyc && wb_stb && !ack_prev;
        ack_prev = 1'b0;
        if (req && wb_we && cnt < DEPTH) begin
          p = (ecnt + 1 > last_pop + G + 1) ? ecnt + 1 : last_pop + G + 1;
          last_pop = p;
          pend.push_back(p);
          be.adr = wb_adr;
          be.dat = wb_wdat;
          be.edge_n = p;
          bq.push_back(be);
          we.edge_n = ecnt;
          we.is_rd = 1'b0;
          we.dat = 32'h0;
          wq.push_back(we);
          ack_prev = 1'b1;
        end else if (req && !wb_we) begin
          we.edge_n = ecnt;
          we.is_rd = 1'b1;
          we.dat = {23'h0, (cnt == DEPTH), 8'(cnt)};
          wq.push_back(we);
          ack_prev = 1'b1;
        end
        cnt = 0;
        foreach (pend[k]) if (pend[k] > ecnt) cnt++;
        exp_full = (cnt == DEPTH);
      end
    end

    // ----------------------------- monitor --------------------------------
    always @(posedge clk) begin : p_mon
      #1;
      if (wq.size() > 0 && wq[0].edge_n == ecnt) begin
        $display("[%0t] g%0d ack %s dat=%h", $time, gi, wq[0].is_rd ? "rd" : "wr", wb_rdat);
        chk(gi, "ack", 32'(wb_ack), 32'd1);
        chk(gi, "ack_dat", wb_rdat, wq[0].dat);
        void'(wq.pop_front());
      end else begin
        chk(gi, "no_ack", 32'(wb_ack), 32'd0);
        chk(gi, "dat_idle", wb_rdat, 32'h0);
      end
      if (bq.size() > 0 && bq[0].edge_n == ecnt) begin
        $display("[%0t] g%0d bus adr=%h dat=%h", $time, gi, bus_adr, bus_dat);
        chk(gi, "bus_vld", 32'(bus_vld), 32'd1);
        chk(gi, "bus_adr", bus_adr, bq[0].adr);
        chk(gi, "bus_dat", bus_dat, bq[0].dat);
        void'(bq.pop_front());
      end else begin
        chk(gi, "bus_vld_idle", 32'(bus_vld), 32'd0);
        chk(gi, "bus_adr_idle", bus_adr, IDLE);
        chk(gi, "bus_dat_idle", bus_dat, 32'h0);
      end
      chk(gi, "fifo_full", 32'(fifo_full), 32'(exp_full));
    end

    // Reset must take effect without waiting for a clock edge.
    always @(negedge rst_n) begin
      #1;
      $display("[%0t] g%0d async reset", $time, gi);
      chk(gi, "rst_ack", 32'(wb_ack), 32'd0);
      chk(gi, "rst_bus_adr", bus_adr, IDLE);
      chk(gi, "rst_bus_dat", bus_dat, 32'h0);
      chk(gi, "rst_bus_vld", 32'(bus_vld), 32'd0);
      chk(gi, "rst_full", 32'(fifo_full), 32'd0);
    end

    // ----------------------------- driver ---------------------------------
    task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int abandon, input bit keep);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b1;
      wb_adr = a;
      wb_wdat = d;
      for (int k = 1; k <= ACK_BUDGET; k++) begin
        @(posedge clk);
        #1;
        if (wb_ack) begin
          if (!keep) begin
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
          end
          return;
        end
        if (abandon > 0 && k >= abandon) begin
          $display("[%0t] g%0d write adr=%h abandoned", $time, gi, a);
          wb_cyc = 1'b0;
          wb_stb = 1'b0;
          return;
        end
      end
      fail_bound(gi, "write_ack");
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
    endtask

    task automatic do_read();
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b0;
      for (int k = 1; k <= ACK_BUDGET; k++) begin
        @(posedge clk);
        #1;
        if (wb_ack) begin
          wb_cyc = 1'b0;
          wb_stb = 1'b0;
          return;
        end
      end
      fail_bound(gi, "read_ack");
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
    endtask

    task automatic wait_drained();
      for (int k = 0; k < DRAIN_BUDGET; k++) begin
        if (bq.size() == 0) return;
        @(posedge clk);
        #1;
      end
      fail_bound(gi, "drain");
    endtask

    initial begin : p_drv
      // Asynchronous reset before the first clock edge, released after one.
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(5);

      // Single write into an empty FIFO.
      do_write(32'h0000_0005, 32'h0000_ABCD, 0, 1'b0);
      idle(3);
      wait_drained();

      // Burst of ten back-to-back writes, strobe held between them.
      for (int i = 0; i < 10; i++) do_write(32'(i), $urandom(), 0, 1'b1);
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      do_read();
      wait_drained();

      // Status read with entries queued.
      for (int i = 0; i < 4; i++) do_write(32'h100 + 32'(i), $urandom(), 0, 1'b0);
      do_read();
      wait_drained();

      // Fill towards full, giving up after a short stall (cyc dropped).
      for (int i = 0; i < 12; i++) do_write(32'h200 + 32'(i), $urandom(), 3, 1'b0);
      do_read();

      // Randomised mix of reads, writes, idles and abandoned stalls.
      for (int t = 0; t < 40; t++) begin
        if ($urandom_range(0, 3) == 0) begin
          do_read();
        end else begin
          do_write($urandom(), $urandom(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   1'($urandom_range(0, 1)));
        end
        if (!wb_cyc) idle(int'($urandom_range(0, 3)));
      end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wait_drained();

      // Reset mid-cycle with entries queued: everything is discarded.
      for (int i = 0; i < 5; i++) do_write(32'h300 + 32'(i), $urandom(), 0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(6);
      do_read();
      idle(3);
      wait_drained();

      n_done++;
    end
  end

  initial begin : p_end
    for (int t = 0; t < GLOBAL_BUDGET && n_done < NI; t++) @(posedge clk);
    if (n_done < NI) fail_bound(-1, "global");
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
